// File: rtl/terminal_arbiter.sv
// Terminal arbiter: shares the LED matrix (terminal 0) and the LED bar (terminal 1)
// between stations HH0/HH1. Each terminal has an ownership FSM with round-robin
// tie-break and bounded hold time. A same-ID request pair locks both terminals out.
module terminal_arbiter #(
   parameter int HOLD_CYCLES = 50000000,
   parameter int LOCK_CYCLES = 100000000,
   parameter int CNT_W       = 27
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic       SEL0,
   input  logic       SEL1,
   input  logic [2:0] CF0,
   input  logic [2:0] CF1,
   input  logic [2:0] ID0,
   input  logic [2:0] ID1,
   output logic [2:0] FMATRIZ,
   output logic [2:0] FLEDS,
   output logic [1:0] GNT_MATRIZ,
   output logic [1:0] GNT_LEDS,
   output logic       CONFLITO,
   output logic       SEL7SEG
);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      LIVRE = 2'b00,
      OCUP0 = 2'b01,
      OCUP1 = 2'b10
   } term_st_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

   // Index 0 = matrix, index 1 = LED bar.
   term_st_t         st_q   [2];
   term_st_t         st_d   [2];
   logic [2:0]       code_q [2];
   logic [2:0]       code_d [2];
   logic [CNT_W-1:0] hold_q [2];
   logic [CNT_W-1:0] hold_d [2];
   logic             ptr_q  [2];
   logic             ptr_d  [2];
   logic [1:0]       elig   [2];
   logic             win    [2];
   logic [1:0]       rearm_q, rearm_d;
   logic [CNT_W-1:0] lock_q, lock_d;
   logic             conf_q, conf_d;
   logic             sel7_q, sel7_d;
   logic [1:0]       owns;
   logic [1:0]       ok;
   logic [1:0]       req;
   logic [1:0]       sel;
   logic [2:0]       cf     [2];

   assign req   = {REQ1, REQ0};
   assign sel   = {SEL1, SEL0};
   assign cf[0] = CF0;
   assign cf[1] = CF1;

   // A station owns a terminal when either FSM carries its grant bit.
   assign owns = st_q[0] | st_q[1];
   assign ok[0] = REQ0 && (CF0 != 3'b000) && rearm_q[0] && !owns[0];
   assign ok[1] = REQ1 && (CF1 != 3'b000) && rearm_q[1] && !owns[1];
   assign elig[0] = {ok[1] & ~SEL1, ok[0] & ~SEL0};
   assign elig[1] = {ok[1] &  SEL1, ok[0] &  SEL0};

   // Next-state logic: lockout first, otherwise both terminals arbitrate independently.
   always_comb begin
      for (int t = 0; t < 2; t++) begin
         st_d[t]   = st_q[t];
         code_d[t] = code_q[t];
         hold_d[t] = hold_q[t];
         ptr_d[t]  = ptr_q[t];
         win[t]    = 1'b0;
      end
      rearm_d = rearm_q;
      lock_d  = lock_q;
      conf_d  = conf_q;
      sel7_d  = sel7_q;

      // Re-arm once a station has let go of its request.
      for (int i = 0; i < 2; i++) begin
         if (!req[i]) rearm_d[i] = 1'b1;
      end

      if (conf_q) begin
         // Terminals are already idle; just run out the lock time.
         if (lock_q == LOCK_LAST) begin
            conf_d = 1'b0;
            lock_d = '0;
         end else begin
            lock_d = lock_q + 1'b1;
         end
      end else if (REQ0 && REQ1 && (ID0 == ID1)) begin
         conf_d = 1'b1;
         lock_d = '0;
         for (int t = 0; t < 2; t++) begin
            st_d[t]   = LIVRE;
            code_d[t] = 3'b000;
            hold_d[t] = '0;
         end
      end else begin
         // LED bar is evaluated last, so it sets the 7-seg station on a simultaneous grant.
         for (int t = 0; t < 2; t++) begin
            if (st_q[t] == LIVRE) begin
               if (elig[t] != 2'b00) begin
                  if (elig[t] == 2'b11) begin
                     win[t]   = ptr_q[t];
                     ptr_d[t] = ~ptr_q[t];
                  end else begin
                     win[t] = elig[t][1];
                  end
                  st_d[t]   = win[t] ? OCUP1 : OCUP0;
                  code_d[t] = cf[win[t]];
                  hold_d[t] = '0;
                  sel7_d    = win[t];
               end
            end else begin
               win[t] = st_q[t][1];
               if (!req[win[t]]) begin
                  st_d[t]   = LIVRE;
                  code_d[t] = 3'b000;
                  hold_d[t] = '0;
               end else if (hold_q[t] == HOLD_LAST) begin
                  st_d[t]   = LIVRE;
                  code_d[t] = 3'b000;
                  hold_d[t] = '0;
                  rearm_d[win[t]] = 1'b0;
               end else begin
                  hold_d[t] = hold_q[t] + 1'b1;
               end
            end
         end
      end
   end

   // State registers with asynchronous reset to idle, pointers at station 0, re-armed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int t = 0; t < 2; t++) begin
            st_q[t]   <= LIVRE;
            code_q[t] <= 3'b000;
            hold_q[t] <= '0;
            ptr_q[t]  <= 1'b0;
         end
         rearm_q <= 2'b11;
         lock_q  <= '0;
         conf_q  <= 1'b0;
         sel7_q  <= 1'b0;
      end else begin
         for (int t = 0; t < 2; t++) begin
            st_q[t]   <= st_d[t];
            code_q[t] <= code_d[t];
            hold_q[t] <= hold_d[t];
            ptr_q[t]  <= ptr_d[t];
         end
         rearm_q <= rearm_d;
         lock_q  <= lock_d;
         conf_q  <= conf_d;
         sel7_q  <= sel7_d;
      end
   end

   assign FMATRIZ    = code_q[0];
   assign FLEDS      = code_q[1];
   assign GNT_MATRIZ = st_q[0];
   assign GNT_LEDS   = st_q[1];
   assign CONFLITO   = conf_q;
   assign SEL7SEG    = sel7_q;

endmodule

// File: doc/terminal_arbiter.md
Name: terminal_arbiter

Overview:
Sequential arbiter that shares the two output terminals (LED matrix and LED bar) between the two access stations HH0/HH1. It replaces the purely combinational terminal-select path with a per-terminal ownership state machine. The state machine has round-robin tie-break, a bounded hold time, re-arm after forced release, and a lockout when both stations present the same user ID. It sits between the per-station function encoders/destination selectors and the matrix/LED decoders, and also drives the 7-segment station select.

Parameters:
HOLD_CYCLES, 50000000, maximum cycles a station may own a terminal (1 s at 50 MHz); must be >= 2
LOCK_CYCLES, 100000000, cycles both terminals stay blocked after a same-ID conflict; must be >= 2
CNT_W, 27, counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, LOCK_CYCLES)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ0  in  1  station 0 request level (synchronised upstream)
REQ1  in  1  station 1 request level
SEL0  in  1  station 0 destination: 0 = matrix, 1 = LEDs
SEL1  in  1  station 1 destination
CF0  in  3  station 0 function code; 3'b000 = no valid function
CF1  in  3  station 1 function code
ID0  in  3  station 0 user ID
ID1  in  3  station 1 user ID
FMATRIZ  out  3  function code driven to matrix decoder
FLEDS  out  3  function code driven to LED decoder
GNT_MATRIZ  out  2  one-hot matrix owner: bit0 = station 0, bit1 = station 1
GNT_LEDS  out  2  one-hot LED owner
CONFLITO  out  1  same-ID lockout active
SEL7SEG  out  1  station whose ID is shown on 7-seg (last granted)

Behaviour:
- Clock and reset: one clock domain. RST is asynchronous and active-high. All outputs are registered.
- Reset values: all outputs 0. Both terminal FSMs in LIVRE. Both priority pointers = station 0. Both re-arm flags set. All counters 0.
- Terminal FSMs: two identical instances, MATRIZ (destination 0) and LEDS (destination 1). States are LIVRE, OCUP0, OCUP1.
- Eligibility: station i is eligible for terminal T when all of the following hold:
  - REQi=1;
  - CFi!=0;
  - SELi selects T;
  - re-arm flag i is set;
  - station i owns neither terminal;
  - CONFLITO=0.
- LIVRE, single eligible station i: on the next edge go to OCUPi, latch CFi into the terminal code register, set GNT bit i, set SEL7SEG=i, clear the hold counter. Grant latency is 1 cycle from eligibility.
- LIVRE, both stations eligible: grant the station named by the terminal's priority pointer, then toggle that pointer.
- OCUPi, per cycle: the hold counter increments.
- OCUPi, voluntary release: REQi=0 → go to LIVRE next edge, code register and GNT cleared.
- OCUPi, forced release: counter reaches HOLD_CYCLES-1 with REQi still 1 → go to LIVRE and clear re-arm flag i. The flag is set again only after REQi has been sampled 0.
- LIVRE after a release: always lasts at least 1 cycle, with outputs 0, before any new grant. There is no direct OCUP0→OCUP1 transition.
- Latched code while owned: changes on CFi and SELi are ignored. The latched code stays until release. A station never owns both terminals.
- Conflict detection: REQ0=1, REQ1=1 and ID0==ID1 sampled on an edge → CONFLITO=1 on the next edge. Both FSMs are forced to LIVRE and both GNTs and codes are cleared in that same cycle. The lock counter starts.
- Conflict hold: CONFLITO stays 1 for exactly LOCK_CYCLES cycles. When it ends, CONFLITO clears. If the condition is still present, it re-asserts on the following edge.
- During lock: requests are ignored. Priority pointers are unchanged. SEL7SEG holds its value.
- Independence: the two terminals arbitrate in the same cycle, each with its own pointer.
- Reset mid-operation: all outputs return to 0 immediately (asynchronous). Any ownership or lockout in progress is discarded.

Test Plan:
- Single grant (HOLD_CYCLES=8, LOCK_CYCLES=6): REQ0=1, SEL0=0, CF0=3'b101 → next edge FMATRIZ=101, GNT_MATRIZ=01, SEL7SEG=0. Drop REQ0 → next edge FMATRIZ=000, GNT_MATRIZ=00.
- Tie-break: both stations request the matrix in the same cycle (CF0=010, CF1=110) from reset → station 0 wins (GNT_MATRIZ=01). After release plus the 1-cycle gap, a repeated tie → station 1 wins (GNT_MATRIZ=10).
- Forced release: station 0 holds REQ0=1 for 20 cycles → GNT_MATRIZ=01 for exactly 8 cycles, then 00 with no regrant. Station 1 waiting on the matrix gets it 1 cycle after release. Station 0 is regranted only after REQ0 goes 0 then 1.
- Parallel terminals: station 0 requests the matrix (CF0=001) and station 1 requests the LEDs (CF1=100) in the same cycle → both granted next edge: FMATRIZ=001, FLEDS=100.
- Conflict: ID0=ID1=3'b011 with both REQ high while station 0 owns the LEDs → next edge CONFLITO=1, FLEDS=000, GNTs=00, held 6 cycles. Clear the IDs → no re-assert.
- Async reset: assert RST mid-hold with the counter at 4 → outputs 0 before the next CLK edge. Deassert RST → the first grant follows the reset pointer (station 0).
